// File: rtl/fetch_sequencer_pkg.sv
// Shared constants for the fetch sequencer and its instruction class decoder:
// opcode values, FSM state encoding and default widths/limits.
package fetch_sequencer_pkg;

  localparam int INSTR_WORD_WIDTH   = 8;   // default PC / program address width
  localparam int OP_W_DEF           = 4;   // default opcode field width
  localparam int TIMEOUT_CYCLES_DEF = 16;  // default fetch watchdog limit

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_JMPC = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  // One-hot class of an opcode; anything that is not control flow is exec.
  typedef struct packed {
    logic is_nop;
    logic is_jmp;
    logic is_jmpc;
    logic is_halt;
    logic is_exec;
  } instr_class_t;

endpackage

// File: rtl/fetch_sequencer_instr_class_decoder.sv
// Combinational opcode classifier, shared by the fetch sequencer and the
// execute unit so both agree on what counts as a control-flow opcode.
module instr_class_decoder
  import fetch_sequencer_pkg::*;
#(
  parameter int OP_WIDTH = OP_W_DEF
) (
  input  logic [OP_WIDTH-1:0] opcode,
  output instr_class_t        cls
);

  // Classify the opcode; exec is the fall-through for every other value.
  always_comb begin
    cls         = '0;
    cls.is_nop  = (opcode == OP_WIDTH'(OP_NOP));
    cls.is_jmp  = (opcode == OP_WIDTH'(OP_JMP));
    cls.is_jmpc = (opcode == OP_WIDTH'(OP_JMPC));
    cls.is_halt = (opcode == OP_WIDTH'(OP_HALT));
    cls.is_exec = !(cls.is_nop || cls.is_jmp || cls.is_jmpc || cls.is_halt);
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: fetches the word at the PC, resolves NOP/JMP/JMPC/HALT
// locally (PC step/load pulses) and hands every other opcode to the execute
// unit over valid/ready.
// Optional feature macro: FETCH_TIMEOUT_EN (fetch watchdog, sticky fault).
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH     = INSTR_WORD_WIDTH,
  parameter int OP_WIDTH       = OP_W_DEF,
  parameter int IW             = OP_WIDTH + ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] pc_addr,
  output logic                  pc_en,
  output logic                  pc_we,
  output logic [ADDR_WIDTH-1:0] pc_load,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [IW-1:0]         mem_rdata,
  input  logic                  mem_ack,
  input  logic                  cond_flag,
  output logic [IW-1:0]         instr,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic                  halted,
  output logic                  fault
);

  state_t       state;
  instr_class_t cls;
  logic         in_issue;
  logic         take_jmp;
  logic         to_hit;

  instr_class_decoder #(.OP_WIDTH(OP_WIDTH)) u_dec (
    .opcode (instr[IW-1 -: OP_WIDTH]),
    .cls    (cls)
  );

  // PC pulses are decoded in the ISSUE cycle so the PC updates on the same
  // edge the FSM returns to FETCH and the new address is presented at once.
  assign in_issue    = (state == S_ISSUE);
  assign take_jmp    = cls.is_jmp || (cls.is_jmpc && cond_flag);
  assign instr_valid = in_issue && cls.is_exec;
  assign pc_we       = in_issue && take_jmp;
  assign pc_en       = in_issue && (cls.is_nop || (cls.is_jmpc && !cond_flag) ||
                                    (cls.is_exec && instr_ready));
  assign pc_load     = instr[ADDR_WIDTH-1:0];
  assign mem_req     = (state == S_FETCH);
  assign mem_addr    = pc_addr;
  assign halted      = (state == S_HALT);

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] to_cnt;
  logic          fault_q;

  // Last un-acked FETCH cycle before the limit; a same-cycle ack wins.
  assign to_hit = (state == S_FETCH) && !mem_ack && (to_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign fault  = fault_q;

  // Watchdog: counter sits at zero outside FETCH so each fetch starts fresh;
  // fault stays set until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt  <= '0;
      fault_q <= 1'b0;
    end else begin
      if (state != S_FETCH)  to_cnt <= '0;
      else if (!mem_ack)     to_cnt <= to_cnt + 1'b1;
      if (to_hit)            fault_q <= 1'b1;
    end
  end
`else
  localparam int timeout_unused = TIMEOUT_CYCLES;
  assign to_hit = 1'b0;
  assign fault  = 1'b0;
`endif

  // Main sequencer FSM and instruction register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      instr <= '0;
    end else begin
      case (state)
        S_IDLE:  state <= S_FETCH;
        S_FETCH: begin
          if (mem_ack) begin
            instr <= mem_rdata;
            state <= S_ISSUE;
          end else if (to_hit) begin
            state <= S_HALT;
          end
        end
        S_ISSUE: begin
          if (cls.is_halt)                       state <= S_HALT;
          else if (!cls.is_exec || instr_ready)  state <= S_FETCH;
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
